// File: rtl/mips_mem_pkg.sv
// -----------------------------------------------------------------------------
// mips_mem_pkg
//   Shared definitions for the MEM-stage data-memory access controller:
//   FSM state encoding, MIPS load/store opcodes, access-size enum and the
//   byte-enable width.
//   Configuration macro: SUBWORD_EN (consumers use the opcode/size items only
//   when it is defined).
// -----------------------------------------------------------------------------
package mips_mem_pkg;

    // Controller states: wait for an access, drive the bus, report the result
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Load/store opcodes (instruction bits [31:26])
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    // Access size of a load or store
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    // One enable per byte lane of the 32-bit data bus
    localparam int BE_W = 4;

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// -----------------------------------------------------------------------------
// load_align
//   Combinational load-data alignment: selects the addressed byte/halfword
//   lane of the bus read data (little-endian, lane = offset) and sign- or
//   zero-extends it to 32 bits. Word loads pass through unchanged.
//   Used by mem_access_ctrl only when SUBWORD_EN is defined.
// Ports
//   rdata_i   32  raw bus read data
//   off_i      2  byte offset of the access (addr[1:0])
//   size_i     2  access size (size_e)
//   signed_i   1  1 = sign-extend, 0 = zero-extend
//   ldata_o   32  aligned, extended load result
// -----------------------------------------------------------------------------
module load_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  size_e       size_i,
    input  logic        signed_i,
    output logic [31:0] ldata_o
);

    logic [31:0] shifted;

    // Move the addressed lane down to bit 0 before extending
    assign shifted = rdata_i >> {off_i, 3'b000};

    always_comb begin
        ldata_o = rdata_i;
        case (size_i)
            SZ_BYTE: ldata_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
            SZ_HALF: ldata_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
            default: ldata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//   MEM-stage data-memory access controller. Converts memrd/memwr from the
//   EX/MEM register into one req/ack bus transaction, stalls the pipeline until
//   it finishes, and returns the aligned load result with one-cycle valid,
//   bus-error (ack timeout) and misalignment pulses.
//   FSM: IDLE -> REQ -> DONE -> IDLE (misaligned accesses skip REQ).
//   Configuration macro: SUBWORD_EN
//     defined   : byte/halfword/word accesses decoded from insin[31:26],
//                 lane byte enables, replicated store data, extended loads.
//                 DWIDTH must be 32 in this build.
//     undefined : word-only accesses, dmem_be = 4'hF, insin unused.
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   flush                      squash the access waiting in IDLE
//   memrdin, memwrin           load / store request (both high = store)
//   aluoutin [AWIDTH]          effective address
//   regdata2in [DWIDTH]        store data
//   insin [32]                 instruction (opcode used with SUBWORD_EN)
//   dmem_req/we/addr/wdata/be  data-memory bus request side
//   dmem_ack, dmem_rdata       bus completion and read data (same cycle)
//   stall                      hold the upstream pipeline registers
//   ldata, ldata_vld           load result and its one-cycle valid
//   buserr, misalign           one-cycle error flags in DONE
// -----------------------------------------------------------------------------
module mem_access_ctrl
    import mips_mem_pkg::*;
#(
    parameter int AWIDTH  = 32,
    parameter int DWIDTH  = 32,
    parameter int MAXWAIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              memrdin,
    input  logic              memwrin,
    input  logic [AWIDTH-1:0] aluoutin,
    input  logic [DWIDTH-1:0] regdata2in,
    input  logic [31:0]       insin,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [AWIDTH-1:0] dmem_addr,
    output logic [DWIDTH-1:0] dmem_wdata,
    output logic [BE_W-1:0]   dmem_be,
    input  logic              dmem_ack,
    input  logic [DWIDTH-1:0] dmem_rdata,
    output logic              stall,
    output logic [DWIDTH-1:0] ldata,
    output logic              ldata_vld,
    output logic              buserr,
    output logic              misalign
);

    localparam logic [7:0] MAX_CNT = 8'(MAXWAIT);

    state_e            state_q, state_d;
    logic [AWIDTH-3:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [DWIDTH-1:0] ldata_q, ldata_d;
    logic              isLoad_q, isLoad_d;
    logic [7:0]        waitCnt_q, waitCnt_d;
    logic              buserr_q, buserr_d;
    logic              misalign_q, misalign_d;

    logic              access;
    logic              startReq;
    logic [BE_W-1:0]   accBe;
    logic [DWIDTH-1:0] accWdata;
    logic              accMisalign;
    logic [DWIDTH-1:0] loadResult;

    assign access   = (memrdin | memwrin) & ~flush;
    assign startReq = (state_q == ST_IDLE) & access & ~accMisalign;

`ifdef SUBWORD_EN
    logic [5:0] opcode;
    size_e      accSize, size_q;
    logic       accSigned, sign_q;
    logic [1:0] off_q;

    assign opcode = insin[31:26];

    // Decode access size and signedness; unknown opcodes fall back to word
    always_comb begin
        accSize   = SZ_WORD;
        accSigned = 1'b0;
        case (opcode)
            OP_LB:          begin accSize = SZ_BYTE; accSigned = 1'b1; end
            OP_LBU, OP_SB:  accSize = SZ_BYTE;
            OP_LH:          begin accSize = SZ_HALF; accSigned = 1'b1; end
            OP_LHU, OP_SH:  accSize = SZ_HALF;
            default:        accSize = SZ_WORD;
        endcase
    end

    // Lane enables, replicated store data and alignment check for the access
    always_comb begin
        accBe       = 4'hF;
        accWdata    = regdata2in;
        accMisalign = |aluoutin[1:0];
        case (accSize)
            SZ_BYTE: begin
                accBe       = 4'b0001 << aluoutin[1:0];
                accWdata    = {4{regdata2in[7:0]}};
                accMisalign = 1'b0;
            end
            SZ_HALF: begin
                accBe       = aluoutin[1] ? 4'b1100 : 4'b0011;
                accWdata    = {2{regdata2in[15:0]}};
                accMisalign = aluoutin[0];
            end
            default: ;
        endcase
    end

    // Remember size/sign/offset so the returning data can be aligned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            size_q <= SZ_WORD;
            sign_q <= 1'b0;
            off_q  <= 2'b00;
        end else if (startReq) begin
            size_q <= accSize;
            sign_q <= accSigned;
            off_q  <= aluoutin[1:0];
        end
    end

    load_align u_load_align (
        .rdata_i  (dmem_rdata),
        .off_i    (off_q),
        .size_i   (size_q),
        .signed_i (sign_q),
        .ldata_o  (loadResult)
    );
`else
    logic unusedIns;

    assign unusedIns   = ^insin;
    assign accBe       = 4'hF;
    assign accWdata    = regdata2in;
    assign accMisalign = |aluoutin[1:0];
    assign loadResult  = dmem_rdata;
`endif

    // State and transaction registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            ldata_q    <= '0;
            isLoad_q   <= 1'b0;
            waitCnt_q  <= '0;
            buserr_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            ldata_q    <= ldata_d;
            isLoad_q   <= isLoad_d;
            waitCnt_q  <= waitCnt_d;
            buserr_q   <= buserr_d;
            misalign_q <= misalign_d;
        end
    end

    // Next-state logic. The wait counter holds the number of the current REQ
    // cycle, so reaching MAXWAIT without ack means MAXWAIT cycles have elapsed.
    // Flags default low so they live only for the single DONE cycle.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        ldata_d    = ldata_q;
        isLoad_d   = isLoad_q;
        waitCnt_d  = waitCnt_q;
        buserr_d   = 1'b0;
        misalign_d = 1'b0;
        stall      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                waitCnt_d = '0;
                if (access) begin
                    stall    = 1'b1;
                    isLoad_d = ~memwrin;
                    if (accMisalign) begin
                        misalign_d = 1'b1;
                        ldata_d    = '0;
                        state_d    = ST_DONE;
                    end else begin
                        addr_d    = aluoutin[AWIDTH-1:2];
                        we_d      = memwrin;
                        be_d      = accBe;
                        wdata_d   = accWdata;
                        waitCnt_d = 8'd1;
                        state_d   = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                stall = 1'b1;
                if (dmem_ack) begin
                    if (isLoad_q) begin
                        ldata_d = loadResult;
                    end
                    waitCnt_d = '0;
                    state_d   = ST_DONE;
                end else if (waitCnt_q == MAX_CNT) begin
                    buserr_d  = 1'b1;
                    ldata_d   = '0;
                    waitCnt_d = '0;
                    state_d   = ST_DONE;
                end else begin
                    waitCnt_d = waitCnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus outputs are only driven while a request is outstanding
    assign dmem_req   = (state_q == ST_REQ);
    assign dmem_we    = dmem_req & we_q;
    assign dmem_addr  = dmem_req ? {addr_q, 2'b00} : '0;
    assign dmem_be    = dmem_req ? be_q : '0;
    assign dmem_wdata = dmem_req ? wdata_q : '0;

    assign ldata      = ldata_q;
    assign ldata_vld  = (state_q == ST_DONE) & isLoad_q & ~buserr_q & ~misalign_q;
    assign buserr     = buserr_q;
    assign misalign   = misalign_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//   Self-checking bench for mem_access_ctrl. A bus responder inside doAccess
//   answers requests after a chosen number of REQ cycles; expected load
//   results and error pulses are queued when an access is driven and popped
//   by a monitor when the DUT reports them in DONE.
//   Configuration macro: SUBWORD_EN (enables the sub-word cases).
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        memrdin;
    logic        memwrin;
    logic [31:0] aluoutin;
    logic [31:0] regdata2in;
    logic [31:0] insin;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic [31:0] ldata;
    logic        ldata_vld;
    logic        buserr;
    logic        misalign;

    typedef struct {
        logic [31:0] ldata;
        bit          chkLdata;
        bit          vld;
        bit          buserr;
        bit          misalign;
    } exp_t;

    exp_t sbQ[$];
    exp_t sbItem;
    int   testsRun    = 0;
    int   testsFailed = 0;

    localparam logic [31:0] INS_LW  = 32'h8C00_0000;
    localparam logic [31:0] INS_SW  = 32'hAC00_0000;
    localparam logic [31:0] INS_LB  = 32'h8000_0000;
    localparam logic [31:0] INS_LBU = 32'h9000_0000;
    localparam logic [31:0] INS_SB  = 32'hA000_0000;
    localparam logic [31:0] INS_SH  = 32'hA400_0000;

    mem_access_ctrl #(
        .AWIDTH  (32),
        .DWIDTH  (32),
        .MAXWAIT (15)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .memrdin    (memrdin),
        .memwrin    (memwrin),
        .aluoutin   (aluoutin),
        .regdata2in (regdata2in),
        .insin      (insin),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .stall      (stall),
        .ldata      (ldata),
        .ldata_vld  (ldata_vld),
        .buserr     (buserr),
        .misalign   (misalign)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic pushExp(input logic [31:0] ld, input bit chk, input bit vld, input bit be, input bit ma);
        exp_t e;
        e.ldata    = ld;
        e.chkLdata = chk;
        e.vld      = vld;
        e.buserr   = be;
        e.misalign = ma;
        sbQ.push_back(e);
    endtask

    // Monitor: whenever the DUT reports a result, compare it against the queue
    always begin
        @(negedge clk);
        #2;
        if (rst_n === 1'b1 && (ldata_vld | buserr | misalign) === 1'b1) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpected result pulse", 32'd1, 32'd0);
            end else begin
                sbItem = sbQ.pop_front();
                checkOutput("sb buserr", {31'd0, buserr}, {31'd0, sbItem.buserr});
                checkOutput("sb misalign", {31'd0, misalign}, {31'd0, sbItem.misalign});
                if (!sbItem.buserr && !sbItem.misalign)
                    checkOutput("sb ldata_vld", {31'd0, ldata_vld}, {31'd0, sbItem.vld});
                if (sbItem.chkLdata)
                    checkOutput("sb ldata", ldata, sbItem.ldata);
            end
        end
    end

    // Drive one access from IDLE, play the bus slave (ack in REQ cycle
    // ackAfter, 0 = never), and count stall/req/valid cycles until DONE.
    task automatic applyStimulus(
        input string       tag,
        input bit          rd,
        input bit          wr,
        input bit          flushIdle,
        input bit          flushReq,
        input logic [31:0] ins,
        input logic [31:0] addr,
        input logic [31:0] wd,
        input int          ackAfter,
        input logic [31:0] rdat,
        input int          expStall,
        input int          expReq,
        input logic [3:0]  expBe,
        input logic [31:0] expWdata,
        input int          expVld
    );
        int stallCnt = 0;
        int reqCnt   = 0;
        int vldCnt   = 0;
        int cyc      = 0;
        bit done     = 1'b0;
        @(negedge clk);
        memrdin    = rd;
        memwrin    = wr;
        flush      = flushIdle;
        insin      = ins;
        aluoutin   = addr;
        regdata2in = wd;
        #1;
        while (!done) begin
            if (ldata_vld) vldCnt++;
            if (dmem_req) begin
                reqCnt++;
                if (reqCnt == 1) begin
                    checkOutput({tag, " addr"}, dmem_addr, addr & 32'hFFFF_FFFC);
                    checkOutput({tag, " we"}, {31'd0, dmem_we}, {31'd0, wr});
                    checkOutput({tag, " be"}, {28'd0, dmem_be}, {28'd0, expBe});
                    if (wr) checkOutput({tag, " wdata"}, dmem_wdata, expWdata);
                    if (flushReq) flush = 1'b1;
                end
                if (reqCnt == ackAfter) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rdat;
                end
            end
            if (stall) stallCnt++;
            else done = 1'b1;
            cyc++;
            if (cyc > 40) begin
                checkOutput({tag, " completion bound"}, 32'd0, 32'd1);
                done = 1'b1;
            end
            if (!done) begin
                @(negedge clk);
                dmem_ack   = 1'b0;
                dmem_rdata = 32'h0;
                #1;
            end
        end
        // Inputs were still asserted in DONE: the stale access must not restart
        @(negedge clk);
        memrdin = 1'b0;
        memwrin = 1'b0;
        flush   = 1'b0;
        #1;
        if (ldata_vld) vldCnt++;
        checkOutput({tag, " no restart"}, {31'd0, dmem_req}, 32'd0);
        checkOutput({tag, " stall cycles"}, stallCnt, expStall);
        checkOutput({tag, " req cycles"}, reqCnt, expReq);
        checkOutput({tag, " ldata_vld cycles"}, vldCnt, expVld);
    endtask

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        memrdin    = 1'b0;
        memwrin    = 1'b0;
        aluoutin   = 32'h0;
        regdata2in = 32'h0;
        insin      = 32'h0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;

        // Reset state
        #12;
        checkOutput("reset req", {31'd0, dmem_req}, 32'd0);
        checkOutput("reset stall", {31'd0, stall}, 32'd0);
        checkOutput("reset ldata", ldata, 32'd0);
        checkOutput("reset ldata_vld", {31'd0, ldata_vld}, 32'd0);
        checkOutput("reset flags", {30'd0, buserr, misalign}, 32'd0);
        checkOutput("reset be", {28'd0, dmem_be}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // LW, ack in first REQ cycle
        pushExp(32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus("LW ack1", 1'b1, 1'b0, 1'b0, 1'b0, INS_LW, 32'h100, 32'h0,
                      1, 32'hDEADBEEF, 2, 1, 4'hF, 32'h0, 1);

        // SW, ack in third REQ cycle
        applyStimulus("SW ack3", 1'b0, 1'b1, 1'b0, 1'b0, INS_SW, 32'h104, 32'h12345678,
                      3, 32'h0, 4, 3, 4'hF, 32'h12345678, 0);

        // Load that is never acknowledged: bus error after 15 REQ cycles
        pushExp(32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus("LW timeout", 1'b1, 1'b0, 1'b0, 1'b0, INS_LW, 32'h180, 32'h0,
                      0, 32'h0, 16, 15, 4'hF, 32'h0, 0);

        // Flush in IDLE squashes the access entirely
        applyStimulus("flush idle", 1'b1, 1'b0, 1'b1, 1'b0, INS_LW, 32'h200, 32'h0,
                      1, 32'h0, 0, 0, 4'hF, 32'h0, 0);

        // Flush raised during REQ is ignored
        pushExp(32'h0BADF00D, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus("flush in REQ", 1'b1, 1'b0, 1'b0, 1'b1, INS_LW, 32'h108, 32'h0,
                      2, 32'h0BADF00D, 3, 2, 4'hF, 32'h0, 1);

        // memrd and memwr together behave as a store
        applyStimulus("rd+wr store", 1'b1, 1'b1, 1'b0, 1'b0, INS_SW, 32'h10C, 32'hA5A5_0F0F,
                      1, 32'hFFFF_FFFF, 2, 1, 4'hF, 32'hA5A5_0F0F, 0);

        // Misaligned word load: no request, misalign pulse in DONE
        pushExp(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus("LW misalign", 1'b1, 1'b0, 1'b0, 1'b0, INS_LW, 32'h102, 32'h0,
                      1, 32'h0, 1, 0, 4'hF, 32'h0, 0);

`ifdef SUBWORD_EN
        // Signed byte load from lane 3
        pushExp(32'hFFFFFF80, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus("LB 0x203", 1'b1, 1'b0, 1'b0, 1'b0, INS_LB, 32'h203, 32'h0,
                      1, 32'h80FF_FF00, 2, 1, 4'b1000, 32'h0, 1);

        // Unsigned byte load from lane 3
        pushExp(32'h00000080, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus("LBU 0x203", 1'b1, 1'b0, 1'b0, 1'b0, INS_LBU, 32'h203, 32'h0,
                      1, 32'h80FF_FF00, 2, 1, 4'b1000, 32'h0, 1);

        // Odd halfword store is misaligned
        pushExp(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus("SH 0x201", 1'b0, 1'b1, 1'b0, 1'b0, INS_SH, 32'h201, 32'h0000_BEEF,
                      1, 32'h0, 1, 0, 4'h0, 32'h0, 0);

        // Byte store to lane 1 with replicated data
        applyStimulus("SB 0x201", 1'b0, 1'b1, 1'b0, 1'b0, INS_SB, 32'h201, 32'h0000_00AB,
                      1, 32'h0, 2, 1, 4'b0010, 32'hABAB_ABAB, 0);
`endif

        // Reset asserted in the middle of a REQ phase
        pushExp(32'hCAFEF00D, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus("LW pre-reset", 1'b1, 1'b0, 1'b0, 1'b0, INS_LW, 32'h300, 32'h0,
                      1, 32'hCAFEF00D, 2, 1, 4'hF, 32'h0, 1);
        @(negedge clk);
        memrdin  = 1'b1;
        insin    = INS_LW;
        aluoutin = 32'h304;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("mid-REQ req before reset", {31'd0, dmem_req}, 32'd1);
        rst_n   = 1'b0;
        memrdin = 1'b0;
        #1;
        checkOutput("reset mid-REQ req", {31'd0, dmem_req}, 32'd0);
        checkOutput("reset mid-REQ stall", {31'd0, stall}, 32'd0);
        checkOutput("reset mid-REQ ldata", ldata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Normal load after reset release
        pushExp(32'h55AA55AA, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus("LW post-reset", 1'b1, 1'b0, 1'b0, 1'b0, INS_LW, 32'h10C, 32'h0,
                      1, 32'h55AA55AA, 2, 1, 4'hF, 32'h0, 1);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard drained", sbQ.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
